// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch-side controller sitting between the PC register,
// instruction memory and decode.
//  - Issues one imem request per cycle while the number of fetches in flight
//    (PCs still waiting for a response plus instructions waiting in the queue)
//    is below DEPTH. This limit means the instruction queue can never overflow.
//  - Tells the PC register what to load next and when to hold.
//  - In-order imem responses are paired with their PC in a small pending-PC
//    FIFO. The pair {pc, instr} is then buffered in a registered queue that
//    decode drains through a valid/ready handshake.
//  - A redirect flushes both FIFOs. Any responses that were still outstanding
//    at that moment are counted in drop_cnt, so they are discarded when they
//    arrive instead of being paired with the wrong PC.
// Ports:
//  clk, rst             clock, synchronous active-high reset
//  pc_i                 current PC from the PC register
//  pc_next_o            value the PC register loads when pc_stall_o = 0
//  pc_stall_o           1 = PC register holds
//  imem_req_*           fetch request (valid/ready, word-aligned address)
//  imem_rsp_*           in-order fetch response, no backpressure
//  redirect_*           branch/jump redirect, highest priority
//  id_valid_o, id_instr_o, id_pc_o, id_ready_i   instruction stream to decode
module if_fetch_ctrl #(
  parameter int DEPTH   = 2,
  parameter int PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o,
  output logic        pc_stall_o,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Stale responses can pile up across back-to-back redirects, so the drop
  // counter is sized well beyond DEPTH.
  localparam int DW = 8;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] STEP_C  = 32'(PC_STEP);

  logic [31:0]   pend_mem [DEPTH];
  logic [AW-1:0] pend_wr, pend_rd;
  logic [CW-1:0] pend_cnt;

  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] q_wr, q_rd;
  logic [CW-1:0] q_cnt;

  logic [DW-1:0] drop_cnt;

  logic [CW:0]   inflight;
  logic          credit;
  logic          fire;
  logic          rsp_take;
  logic          rsp_drop;
  logic          id_pop;
  logic [DW-1:0] drop_sum;
  logic [DW-1:0] drop_redir;

  always_comb begin
    inflight = {1'b0, pend_cnt} + {1'b0, q_cnt};
    credit   = inflight < DEPTH_C;

    imem_req_valid_o = !rst && credit && !redirect_valid_i;
    imem_req_addr_o  = {pc_i[31:2], 2'b00};
    fire             = imem_req_valid_o && imem_req_ready_i;

    // A response with nothing pending would be a protocol error; it is ignored.
    rsp_take = imem_rsp_valid_i && (drop_cnt == '0) && (pend_cnt != '0) && !redirect_valid_i;
    rsp_drop = imem_rsp_valid_i && (drop_cnt != '0) && !redirect_valid_i;

    id_valid_o = !rst && (q_cnt != '0);
    id_instr_o = q_instr[q_rd];
    id_pc_o    = q_pc[q_rd];
    id_pop     = id_valid_o && id_ready_i;

    // On a redirect, every response still owed by imem must be discarded.
    // A response arriving in the redirect cycle itself is already one of them.
    drop_sum   = drop_cnt + DW'(pend_cnt);
    drop_redir = (imem_rsp_valid_i && (drop_sum != '0)) ? drop_sum - DW'(1) : drop_sum;

    pc_stall_o = 1'b1;
    pc_next_o  = pc_i;
    if (rst) begin
      pc_stall_o = 1'b1;
      pc_next_o  = pc_i;
    end else if (redirect_valid_i) begin
      pc_stall_o = 1'b0;
      pc_next_o  = redirect_target_i;
    end else if (fire) begin
      pc_stall_o = 1'b0;
      pc_next_o  = pc_i + STEP_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr  <= '0;
      pend_rd  <= '0;
      pend_cnt <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      q_cnt    <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid_i) begin
      pend_wr  <= '0;
      pend_rd  <= '0;
      pend_cnt <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      q_cnt    <= '0;
      drop_cnt <= drop_redir;
    end else begin
      if (fire)     pend_wr <= pend_wr + AW'(1);
      if (rsp_take) pend_rd <= pend_rd + AW'(1);
      pend_cnt <= pend_cnt + CW'(fire) - CW'(rsp_take);

      if (rsp_take) q_wr <= q_wr + AW'(1);
      if (id_pop)   q_rd <= q_rd + AW'(1);
      q_cnt <= q_cnt + CW'(rsp_take) - CW'(id_pop);

      if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
    end
  end

  // Storage arrays carry no reset; their occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid_i) begin
      if (fire) pend_mem[pend_wr] <= pc_i;
      if (rsp_take) begin
        q_pc[q_wr]    <= pend_mem[pend_rd];
        q_instr[q_wr] <= imem_rsp_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid_i && !redirect_valid_i && (drop_cnt == '0)) begin
      rsp_without_request: assert (pend_cnt != '0);
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl. A behavioural PC register and a behavioural
// imem (fixed one-cycle latency that can be held off) close the loop around
// the DUT. The imem returns ~addr as the instruction word.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_stall;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        hold;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mq[$];

  if_fetch_ctrl #(.DEPTH(2), .PC_STEP(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc),
    .pc_next_o         (pc_next),
    .pc_stall_o        (pc_stall),
    .imem_req_valid_o  (req_valid),
    .imem_req_addr_o   (req_addr),
    .imem_req_ready_i  (req_ready),
    .imem_rsp_valid_i  (rsp_valid),
    .imem_rsp_data_i   (rsp_data),
    .redirect_valid_i  (redirect),
    .redirect_target_i (target),
    .id_valid_o        (id_valid),
    .id_instr_o        (id_instr),
    .id_pc_o           (id_pc),
    .id_ready_i        (id_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) pc <= 32'h0;
    else if (!pc_stall) pc <= pc_next;
  end

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
    end else begin
      if (req_valid && req_ready) mq.push_back(req_addr);
      if (!hold && mq.size() > 0) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ~mq.pop_front();
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b1; id_ready = 1'b1; hold = 1'b0;
    redirect = 1'b0; target = 32'h0;

    // Reset outputs, then streaming with one-cycle responses.
    @(negedge clk); #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_stall", 32'(pc_stall), 32'd1);
    chk("rst_pc_next", pc_next, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("s0_req_valid", 32'(req_valid), 32'd1);
    chk("s0_addr", req_addr, 32'h0);
    chk("s0_pc_next", pc_next, 32'h4);
    chk("s0_stall", 32'(pc_stall), 32'd0);
    @(negedge clk); #1;
    chk("s1_addr", req_addr, 32'h4);
    chk("s1_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk); #1;
    chk("s2_req_valid", 32'(req_valid), 32'd0);
    chk("s2_id_valid", 32'(id_valid), 32'd1);
    chk("s2_id_pc", id_pc, 32'h0);
    chk("s2_id_instr", id_instr, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("s3_addr", req_addr, 32'h8);
    chk("s3_id_pc", id_pc, 32'h4);
    @(negedge clk); #1;
    chk("s4_addr", req_addr, 32'hC);
    chk("s4_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk); #1;
    chk("s5_stall", 32'(pc_stall), 32'd1);
    chk("s5_pc_next", pc_next, 32'h10);
    chk("s5_id_pc", id_pc, 32'h8);
    @(negedge clk); #1;
    chk("s6_addr", req_addr, 32'h10);
    chk("s6_id_pc", id_pc, 32'hC);

    // Decode backpressure, then release.
    reset_dut(); id_ready = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("bp0_addr", req_addr, 32'h0);
    @(negedge clk); #1;
    chk("bp1_addr", req_addr, 32'h4);
    @(negedge clk); #1;
    chk("bp2_req_valid", 32'(req_valid), 32'd0);
    chk("bp2_id_pc", id_pc, 32'h0);
    @(negedge clk); #1;
    chk("bp3_stall", 32'(pc_stall), 32'd1);
    chk("bp3_pc_next", pc_next, 32'h8);
    chk("bp3_id_pc", id_pc, 32'h0);
    chk("bp3_id_instr", id_instr, 32'hFFFF_FFFF);
    @(negedge clk); id_ready = 1'b1; #1;
    chk("bp4_id_pc", id_pc, 32'h0);
    chk("bp4_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk); #1;
    chk("bp5_id_pc", id_pc, 32'h4);
    chk("bp5_addr", req_addr, 32'h8);

    // Reset with the queue full.
    reset_dut(); id_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("full_id_valid", 32'(id_valid), 32'd1);
    chk("full_req_valid", 32'(req_valid), 32'd0);
    rst = 1'b1; #1;
    chk("frst_id_valid", 32'(id_valid), 32'd0);
    chk("frst_stall", 32'(pc_stall), 32'd1);
    chk("frst_pc_next", pc_next, 32'h8);
    @(negedge clk); rst = 1'b0; #1;
    chk("fpost_id_valid", 32'(id_valid), 32'd0);
    chk("fpost_req_valid", 32'(req_valid), 32'd1);
    chk("fpost_addr", req_addr, 32'h0);

    // imem not ready for three cycles at pc 0x10.
    reset_dut(); id_ready = 1'b1;
    @(negedge clk); rst = 1'b0; redirect = 1'b1; target = 32'h10; #1;
    chk("nr_redir_pc_next", pc_next, 32'h10);
    chk("nr_redir_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk); redirect = 1'b0; req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nr_stall", 32'(pc_stall), 32'd1);
      chk("nr_addr", req_addr, 32'h10);
      chk("nr_pc_next", pc_next, 32'h10);
      chk("nr_id_valid", 32'(id_valid), 32'd0);
      @(negedge clk);
    end
    req_ready = 1'b1; #1;
    chk("nr_fire_pc_next", pc_next, 32'h14);
    chk("nr_fire_stall", 32'(pc_stall), 32'd0);
    @(negedge clk); #1;
    chk("nr_rsp_id_valid", 32'(id_valid), 32'd0);
    chk("nr_next_addr", req_addr, 32'h14);
    @(negedge clk); #1;
    chk("nr_id_pc", id_pc, 32'h10);

    // Redirect with two fetches outstanding.
    reset_dut(); hold = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rd0_addr", req_addr, 32'h0);
    @(negedge clk); #1;
    chk("rd1_addr", req_addr, 32'h4);
    @(negedge clk); redirect = 1'b1; target = 32'h100; #1;
    chk("rd2_req_valid", 32'(req_valid), 32'd0);
    chk("rd2_pc_next", pc_next, 32'h100);
    chk("rd2_stall", 32'(pc_stall), 32'd0);
    @(negedge clk); redirect = 1'b0; hold = 1'b0; #1;
    chk("rd3_addr", req_addr, 32'h100);
    @(negedge clk); #1;
    chk("rd4_id_valid", 32'(id_valid), 32'd0);
    chk("rd4_addr", req_addr, 32'h104);
    @(negedge clk); #1;
    chk("rd5_id_valid", 32'(id_valid), 32'd0);
    chk("rd5_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk); #1;
    chk("rd6_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk); #1;
    chk("rd7_id_valid", 32'(id_valid), 32'd1);
    chk("rd7_id_pc", id_pc, 32'h100);
    chk("rd7_id_instr", id_instr, 32'hFFFF_FEFF);

    // PC wrap at the top of the address space.
    reset_dut();
    @(negedge clk); rst = 1'b0; redirect = 1'b1; target = 32'hFFFF_FFFC; #1;
    chk("wr0_pc_next", pc_next, 32'hFFFF_FFFC);
    @(negedge clk); redirect = 1'b0; #1;
    chk("wr1_addr", req_addr, 32'hFFFF_FFFC);
    chk("wr1_pc_next", pc_next, 32'h0);
    @(negedge clk); #1;
    chk("wr2_addr", req_addr, 32'h0);
    @(negedge clk); #1;
    chk("wr3_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wr3_id_instr", id_instr, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
